// File: rtl/hbe_uart_pkg.sv
// Shared UART types: transmitter FSM state encoding
// and the default baud divider (100 MHz / 115200).
package hbe_uart_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..BAUD_DIV-1, one-cycle tick on the last count.
// Ports: clk, clr (sync clear, holds count at 0), tick.
module uart_baud_tick
  import hbe_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one 8N1 UART transmitter.
// Ports: CLK100MHZ, fpga_rst, req0/1 valid/data/ready, uart0_txd, busy, grant_id.
module uart_tx_arbiter
  import hbe_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       CLK100MHZ,
  input  logic       fpga_rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart0_txd,
  output logic       busy,
  output logic       grant_id
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] idx_q, idx_d;
  logic       txd_q, txd_d;
  logic       grant_q, grant_d;
  logic       prio_q, prio_d;
  logic       pick;
  logic       tick;
  logic       baud_clr;

  // Counter sits at 0 through IDLE so START always begins a full bit.
  assign baud_clr = fpga_rst || (state_q == IDLE);

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk (CLK100MHZ),
    .clr (baud_clr),
    .tick(tick)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    idx_d      = idx_q;
    txd_d      = txd_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    pick       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        idx_d = 3'd0;
        if (!fpga_rst && (req0_valid || req1_valid)) begin
          // prio_q names the requester that wins a tie.
          pick       = (req0_valid && req1_valid) ? prio_q : req1_valid;
          req0_ready = !pick;
          req1_ready = pick;
          data_d     = pick ? req1_data : req0_data;
          grant_d    = pick;
          prio_d     = !pick;
          txd_d      = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          txd_d   = data_q[0];
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = data_q[idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  assign uart0_txd = txd_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, contention, reset abort,
// default-divider frame, and a continuous ready checker.
module tb_uart_tx_arbiter;

  localparam int D  = 4;
  localparam int DB = 868;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       r0, r1, txd, busy, gid;

  logic       b_v0 = 1'b0, b_v1 = 1'b0;
  logic [7:0] b_d0 = 8'h00, b_d1 = 8'h00;
  logic       b_r0, b_r1, b_txd, b_busy, b_gid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.BAUD_DIV(D)) dut (
    .CLK100MHZ (clk),
    .fpga_rst  (rst),
    .req0_valid(v0),
    .req0_data (d0),
    .req0_ready(r0),
    .req1_valid(v1),
    .req1_data (d1),
    .req1_ready(r1),
    .uart0_txd (txd),
    .busy      (busy),
    .grant_id  (gid)
  );

  uart_tx_arbiter dut_b (
    .CLK100MHZ (clk),
    .fpga_rst  (rst),
    .req0_valid(b_v0),
    .req0_data (b_d0),
    .req0_ready(b_r0),
    .req1_valid(b_v1),
    .req1_data (b_d1),
    .req1_ready(b_r1),
    .uart0_txd (b_txd),
    .busy      (b_busy),
    .grant_id  (b_gid)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (r0 || r1) begin
      n_tests++;
      if ((r0 && r1) ||
          (r0 && !(v0 && !busy && !rst)) ||
          (r1 && !(v1 && !busy && !rst))) begin
        n_fail++;
        $display("FAIL ready_checker_a: r0=%0b r1=%0b busy=%0b", r0, r1, busy);
      end
    end
    if (b_r0 || b_r1) begin
      n_tests++;
      if ((b_r0 && b_r1) ||
          (b_r0 && !(b_v0 && !b_busy && !rst)) ||
          (b_r1 && !(b_v1 && !b_busy && !rst))) begin
        n_fail++;
        $display("FAIL ready_checker_b: r0=%0b r1=%0b busy=%0b", b_r0, b_r1, b_busy);
      end
    end
  end

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    int         exp_g;
    logic [7:0] exp_byte;
  } vec_t;

  // Starts in an IDLE cycle (edge+1), ends in the next IDLE cycle.
  task automatic send_check(input vec_t t, input string tag);
    logic [9:0]  frame;
    logic [31:0] got;
    logic [31:0] want;
    int          busy_low;
    v0 = t.v0; d0 = t.d0; v1 = t.v1; d1 = t.d1;
    #1;
    check({tag, " ready0"}, r0, t.exp_g == 0);
    check({tag, " ready1"}, r1, t.exp_g == 1);
    step();
    v0 = 1'b0;
    v1 = 1'b0;
    if (t.exp_g < 0) begin
      check({tag, " idle busy"}, busy, 0);
      check({tag, " idle txd"}, txd, 1);
      return;
    end
    check({tag, " busy"}, busy, 1);
    check({tag, " grant"}, gid, t.exp_g);
    frame    = {1'b1, t.exp_byte, 1'b0};
    busy_low = 0;
    for (int b = 0; b < 10; b++) begin
      got  = '0;
      want = frame[b] ? ((32'd1 << D) - 1) : 32'd0;
      for (int c = 0; c < D; c++) begin
        got[c] = txd;
        if (busy !== 1'b1) busy_low++;
        step();
      end
      check($sformatf("%s bit%0d", tag, b), got, want);
    end
    check({tag, " busy_len"}, busy_low, 0);
    check({tag, " end busy"}, busy, 0);
    check({tag, " end txd"}, txd, 1);
  endtask

  vec_t vt[10];
  int   acc_cyc[$];
  int   acc_gid[$];
  int   mism;
  logic [9:0] bframe;

  initial begin
    vt[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 0, 8'hA5};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h3C};
    vt[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 0, 8'h11};
    vt[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1, 8'h22};
    vt[4] = '{1'b0, 8'h00, 1'b1, 8'h7E, 1, 8'h7E};
    vt[5] = '{1'b0, 8'h00, 1'b0, 8'h00, -1, 8'h00};
    vt[6] = '{1'b0, 8'h00, 1'b1, 8'h81, 1, 8'h81};
    vt[7] = '{1'b1, 8'hFF, 1'b1, 8'h00, 0, 8'hFF};
    vt[8] = '{1'b1, 8'h01, 1'b0, 8'h00, 0, 8'h01};
    vt[9] = '{1'b1, 8'h80, 1'b1, 8'h5A, 1, 8'h5A};

    // Reset state, with a request pending that must not be acknowledged.
    rst = 1'b1;
    step();
    v0 = 1'b1;
    d0 = 8'h77;
    step();
    step();
    #1;
    check("rst ready0", r0, 0);
    check("rst txd", txd, 1);
    check("rst busy", busy, 0);
    check("rst grant", gid, 0);
    check("rst b_txd", b_txd, 1);
    v0  = 1'b0;
    rst = 1'b0;

    // First vector lands in the first cycle out of reset.
    foreach (vt[i]) send_check(vt[i], $sformatf("vec%0d", i));

    // Contention: both requesters hold valid continuously.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    v0 = 1'b1; d0 = 8'h11;
    v1 = 1'b1; d1 = 8'h22;
    for (int cyc = 0; cyc < 4 * (10 * D + 1); cyc++) begin
      #1;
      if (r0 || r1) begin
        acc_cyc.push_back(cyc);
        acc_gid.push_back(int'(r1));
      end
      @(posedge clk);
    end
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    check("cont accepts", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4) begin
      check("cont first cyc", acc_cyc[0], 0);
      for (int i = 0; i < 4; i++)
        check($sformatf("cont grant%0d", i), acc_gid[i], i % 2);
      for (int i = 1; i < 4; i++)
        check($sformatf("cont spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 10 * D + 1);
    end

    // Reset during data bit 3 of 0xC3.
    v0 = 1'b1;
    d0 = 8'hC3;
    #1;
    check("abort ready0", r0, 1);
    step();
    v0 = 1'b0;
    repeat (4 + 3 * D + 1) step();
    check("abort bit3 txd", txd, 0);
    check("abort bit3 busy", busy, 1);
    rst = 1'b1;
    v1  = 1'b1;
    d1  = 8'h96;
    step();
    check("abort txd", txd, 1);
    check("abort busy", busy, 0);
    check("abort ready1", r1, 0);
    check("abort grant", gid, 0);
    rst = 1'b0;
    send_check('{1'b0, 8'h00, 1'b1, 8'h96, 1, 8'h96}, "post_abort");

    // Default divider frame.
    b_v0 = 1'b1;
    b_d0 = 8'h55;
    #1;
    check("b ready0", b_r0, 1);
    step();
    b_v0 = 1'b0;
    check("b busy", b_busy, 1);
    check("b grant", b_gid, 0);
    bframe = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      mism = 0;
      for (int c = 0; c < DB; c++) begin
        if (b_txd !== bframe[b] || b_busy !== 1'b1) mism++;
        step();
      end
      check($sformatf("b bit%0d mism", b), mism, 0);
    end
    check("b end busy", b_busy, 0);
    check("b end txd", b_txd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
